mem_stage: RTL
==============

# mem_stage

Pipeline stage directly downstream of the execute-stage ALU. It registers the ALU `Result`, `Overflow` and the instruction's memory attributes. It raises overflow and address-error exceptions, drives the data-SRAM request, and aligns and extends load data. It then hands one result per instruction to write-back using a valid/allowin handshake.

## Interface
- `DATA_WIDTH`, 32, datapath and address width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `es_to_ms_valid`  in  1  execute stage offers an instruction.
- `ms_allowin`  out  1  this stage accepts the offered instruction this cycle.
- `es_alu_result`  in  32  ALU `Result`; it is the data-SRAM address for loads and stores.
- `es_overflow`  in  1  ALU `Overflow`.
- `es_ov_check`  in  1  instruction traps on overflow (add/addi/sub).
- `es_mem_op`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- `es_mem_size`  in  2  00 byte, 01 half, 10 word.
- `es_ld_sign`  in  1  sign-extend load (lb/lh); 0 selects zero-extend.
- `es_st_data`  in  32  store source register value.
- `es_dest`  in  5  destination register.
- `es_gr_we`  in  1  register write enable.
- `data_sram_en`  out  1  SRAM access this cycle.
- `data_sram_wen`  out  4  byte write strobes.
- `data_sram_addr`  out  32  word address: registered `es_alu_result` with bits [1:0] forced to 0.
- `data_sram_wdata`  out  32  store data, byte-replicated.
- `data_sram_rdata`  in  32  read data, valid the cycle after `en`.
- `ws_allowin`  in  1  write-back accepts.
- `ms_to_ws_valid`  out  1  result available.
- `ms_result`  out  32  ALU result or extended load data.
- `ms_dest`  out  5  registered `es_dest`.
- `ms_gr_we`  out  1  registered `es_gr_we`, forced to 0 when the instruction has an exception.
- `ms_ex`  out  1  instruction has an exception.
- `ms_excode`  out  5  0x04 AdEL, 0x05 AdES, 0x0C Ov; 0 when there is no exception.
- `ms_badvaddr`  out  32  faulting address for AdEL/AdES; 0 otherwise.
- `flush`  in  1  synchronous pipeline flush.

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT and HOLD.
- Exception check at accept, in priority order:
  - Ov if `es_ov_check & es_overflow`.
  - Otherwise, for a load or store, AdEL/AdES if the access is half with addr[0]=1, or word with addr[1:0]≠0.
- Next state after accept:
  - Exception or no memory op → HOLD.
  - Load or store → ACCESS.
- An excepting instruction never reaches the SRAM, and its `ms_gr_we` is 0.
- ACCESS:
  - `data_sram_en`=~flush.
  - For a load, `wen`=0000.
  - For a store:
    - byte: `wen`=0001<<addr[1:0], wdata={4{b}}.
    - half: `wen`=addr[1]?1100:0011, wdata={2{h}}.
    - word: `wen`=1111, wdata=st_data.
  - Next state: load → WAIT, store → HOLD.
- WAIT:
  - Captures `data_sram_rdata`.
  - Extracts the byte selected by addr[1:0], or the half selected by addr[1].
  - Sign- or zero-extends per `es_ld_sign`, registers the value as `ms_result`, then goes to HOLD.
- HOLD:
  - `ms_to_ws_valid`=1.
  - On `ws_allowin`: go to the next accepted instruction's state if one is accepted this cycle, else IDLE.
  - Otherwise stay in HOLD with all outputs stable.
- `ms_allowin` = IDLE | (HOLD & ws_allowin). It is 0 in ACCESS and WAIT.
- `flush` overrides every other transition: next state is IDLE and no accept occurs. A flush during ACCESS suppresses `data_sram_en` in that cycle.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except `ms_allowin`=1.
- Reset asserted mid-access aborts the access immediately; `data_sram_en` drops asynchronously.
- Latency from accept edge to `ms_to_ws_valid`:
  - ALU-only or exception: 1 cycle.
  - Store: 2 cycles.
  - Load: 3 cycles.
- Throughput:
  - One ALU-only instruction per cycle when `ws_allowin`=1; back-to-back handover in HOLD has no bubble.
  - A load or store blocks the stage until it drains.
- SRAM outputs are combinational from registered state and `flush`.

## Structure
- Package `mem_stage_pkg` holds:
  - state enum;
  - `MEM_OP_*` and `SIZE_*` constants;
  - `EXC_ADEL`, `EXC_ADES`, `EXC_OV` codes.
- Sub-module `load_align`: combinational rdata + addr[1:0] + size + sign → 32-bit extended value, instantiated once and used in WAIT.

## Test plan
- ALU-only, result 0x0000_1234, `ws_allowin`=1 → next cycle `ms_to_ws_valid`=1, `ms_result`=0x1234, `data_sram_en` never asserted.
- lb addr 0x103, sign=1, rdata 0x80FF_FF7F → `ms_result`=0xFFFF_FF80 three cycles after accept.
- sh addr 0x202, data 0x0000_BEEF → ACCESS cycle `wen`=1100, `wdata`=0xBEEF_BEEF, `addr`=0x200.
- lw addr 0x101 → `ms_ex`=1, `excode`=0x04, `badvaddr`=0x101, no SRAM access, `ms_gr_we`=0. add with overflow=1 → `excode`=0x0C.
- Load in ACCESS with `flush`=1 → `data_sram_en`=0 that cycle, next state IDLE, `ms_to_ws_valid` stays 0.
- HOLD with `ws_allowin`=0 for 3 cycles, then 1, with a new valid instruction offered → outputs stable while stalled, new instruction accepted on the release cycle; reset asserted during WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory pipeline stage.
//   state_e        - stage FSM states
//   MEM_OP_*       - es_mem_op encodings (2'b11 is reserved and behaves as none)
//   SIZE_*         - es_mem_size encodings
//   EXC_*          - exception codes reported on ms_excode
//   misaligned()   - address-error test for a half or word access
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half of a 32-bit SRAM read word and
// sign- or zero-extends it to 32 bits.
//   rdata_i   - raw SRAM read word
//   addr_lo_i - byte offset of the access within the word
//   size_i    - access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   sign_i    - 1 sign-extends, 0 zero-extends
//   value_o   - extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SIZE_BYTE: value_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: value_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default:   value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage after the execute-stage ALU. Registers the ALU
// result and memory attributes, raises Ov/AdEL/AdES, drives the data SRAM,
// aligns load data and hands one result per instruction to write-back.
//   clk, reset                    - clock, async active-high reset
//   es_to_ms_valid / ms_allowin   - handshake from execute stage
//   es_*                          - instruction fields from execute stage
//   data_sram_*                   - SRAM request (read data one cycle after en)
//   ws_allowin / ms_to_ws_valid   - handshake to write-back
//   ms_*                          - result, destination and exception info
//   flush                         - synchronous pipeline flush
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  es_to_ms_valid,
  output logic                  ms_allowin,
  input  logic [DATA_WIDTH-1:0] es_alu_result,
  input  logic                  es_overflow,
  input  logic                  es_ov_check,
  input  logic [1:0]            es_mem_op,
  input  logic [1:0]            es_mem_size,
  input  logic                  es_ld_sign,
  input  logic [DATA_WIDTH-1:0] es_st_data,
  input  logic [4:0]            es_dest,
  input  logic                  es_gr_we,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_wen,
  output logic [DATA_WIDTH-1:0] data_sram_addr,
  output logic [DATA_WIDTH-1:0] data_sram_wdata,
  input  logic [DATA_WIDTH-1:0] data_sram_rdata,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic [DATA_WIDTH-1:0] ms_result,
  output logic [4:0]            ms_dest,
  output logic                  ms_gr_we,
  output logic                  ms_ex,
  output logic [4:0]            ms_excode,
  output logic [DATA_WIDTH-1:0] ms_badvaddr,
  input  logic                  flush
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] addr_q, st_data_q, badvaddr_q;
  logic [1:0]            size_q;
  logic                  is_load_q, sign_q, gr_we_q, ex_q;
  logic [4:0]            dest_q, excode_q;

  logic                  accept, is_load_in, is_mem_in, ov_ex, ad_ex, ex_in;
  logic [4:0]            excode_in;
  logic [DATA_WIDTH-1:0] badv_in, load_value;
  state_e                accept_state;
  logic [3:0]            strobe;

  // Accept decode: Ov outranks address errors.
  always_comb begin
    is_load_in   = (es_mem_op == MEM_OP_LOAD);
    is_mem_in    = is_load_in | (es_mem_op == MEM_OP_STORE);
    ov_ex        = es_ov_check & es_overflow;
    ad_ex        = is_mem_in & misaligned(es_mem_size, es_alu_result[1:0]);
    ex_in        = ov_ex | ad_ex;
    excode_in    = ov_ex ? EXC_OV : (ad_ex ? (is_load_in ? EXC_ADEL : EXC_ADES) : EXC_NONE);
    badv_in      = (!ov_ex && ad_ex) ? es_alu_result : '0;
    accept_state = (ex_in || !is_mem_in) ? ST_HOLD : ST_ACCESS;
  end

  assign ms_allowin = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & ws_allowin);
  assign accept     = es_to_ms_valid & ms_allowin & ~flush;

  load_align u_load_align (
    .rdata_i   (data_sram_rdata),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .sign_i    (sign_q),
    .value_o   (load_value)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = accept_state;
      ST_ACCESS: state_d = is_load_q ? ST_WAIT : ST_HOLD;
      ST_WAIT: begin
        state_d  = ST_HOLD;
        result_d = load_value;
      end
      default:   if (ws_allowin) state_d = accept ? accept_state : ST_IDLE;
    endcase
    if (accept) result_d = es_alu_result;
    if (flush)  state_d  = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      addr_q     <= '0;
      st_data_q  <= '0;
      badvaddr_q <= '0;
      size_q     <= '0;
      is_load_q  <= 1'b0;
      sign_q     <= 1'b0;
      gr_we_q    <= 1'b0;
      ex_q       <= 1'b0;
      dest_q     <= '0;
      excode_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        addr_q     <= es_alu_result;
        st_data_q  <= es_st_data;
        badvaddr_q <= badv_in;
        size_q     <= es_mem_size;
        is_load_q  <= is_load_in;
        sign_q     <= es_ld_sign;
        gr_we_q    <= es_gr_we & ~ex_in;
        ex_q       <= ex_in;
        dest_q     <= es_dest;
        excode_q   <= excode_in;
      end
    end
  end

  // SRAM request is combinational from registered state so reset drops it at once.
  always_comb begin
    case (size_q)
      SIZE_BYTE: strobe = 4'b0001 << addr_q[1:0];
      SIZE_HALF: strobe = addr_q[1] ? 4'b1100 : 4'b0011;
      default:   strobe = 4'b1111;
    endcase
    case (size_q)
      SIZE_BYTE: data_sram_wdata = {4{st_data_q[7:0]}};
      SIZE_HALF: data_sram_wdata = {2{st_data_q[15:0]}};
      default:   data_sram_wdata = st_data_q;
    endcase
  end

  assign data_sram_en   = (state_q == ST_ACCESS) & ~flush;
  assign data_sram_wen  = (data_sram_en & ~is_load_q) ? strobe : 4'b0000;
  assign data_sram_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};

  assign ms_to_ws_valid = (state_q == ST_HOLD);
  assign ms_result      = result_q;
  assign ms_dest        = dest_q;
  assign ms_gr_we       = gr_we_q;
  assign ms_ex          = ex_q;
  assign ms_excode      = excode_q;
  assign ms_badvaddr    = badvaddr_q;

endmodule
